// File: rtl/edm_pkg.sv
// Shared EDM definitions: waveform bit layout, scheduler FSM encoding, error-flag
// bit positions and the reset/limit values of the discharge parameter set.
package edm_pkg;

    localparam int WAVE_RES_BIT    = 15;
    localparam int WAVE_SINGLE_BIT = 14;
    localparam int WAVE_CLOSED_BIT = 13;

    typedef enum logic [1:0] {
        STOPPED = 2'd0,
        RUNNING = 2'd1,
        DRAIN   = 2'd2
    } sched_state_t;

    localparam int ERR_TON  = 0;
    localparam int ERR_TOFF = 1;
    localparam int ERR_IP   = 2;
    localparam int ERR_WAVE = 3;

    localparam logic [15:0] TON_MIN_DEF  = 16'd10;
    localparam logic [15:0] TON_MAX_DEF  = 16'd5000;
    localparam logic [15:0] TOFF_MIN_DEF = 16'd20;
    localparam logic [15:0] TOFF_MAX_DEF = 16'd60000;
    localparam logic [15:0] IP_MIN_DEF   = 16'd1;
    localparam logic [15:0] IP_MAX_DEF   = 16'd120;
    localparam logic [15:0] TON_RST_DEF  = 16'd100;
    localparam logic [15:0] TOFF_RST_DEF = 16'd1000;
    localparam logic [15:0] IP_RST_DEF   = 16'd20;
    localparam logic [15:0] WAVE_RST_DEF = 16'h2001;
    localparam logic [15:0] STOP_TMO_DEF = 16'd20000;

    // RES topology carries no shape bits; BUCK needs a nonzero shape selector in [1:0].
    function automatic logic wave_shape_legal(input logic [15:0] w);
        if (w[WAVE_RES_BIT])
            return (w[14:0] == 15'd0);
        else
            return (w[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/param_shadow_reg.sv
// One range-checked shadow register: a legal write is captured and clears the
// field's error bit, an out-of-range write is dropped and sets it.
module param_shadow_reg
    import edm_pkg::*;
#(
    parameter logic [15:0] MIN = 16'd0,
    parameter logic [15:0] MAX = 16'hffff,
    parameter logic [15:0] RST = 16'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr,
    input  logic [15:0] din,
    output logic [15:0] shadow,
    output logic        err
);

    logic legal;

    assign legal = (din >= MIN) && (din <= MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= RST;
            err    <= 1'b0;
        end else if (wr) begin
            if (legal) begin
                shadow <= din;
                err    <= 1'b0;
            end else begin
                err    <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/discharge_param_scheduler.sv
// Start/stop arbitration and atomic commit of the Ton/Toff/Ip/waveform set into
// the active registers seen by discharge_control, only at safe points.
module discharge_param_scheduler
    import edm_pkg::*;
#(
    parameter logic [15:0] TON_MIN  = TON_MIN_DEF,
    parameter logic [15:0] TON_MAX  = TON_MAX_DEF,
    parameter logic [15:0] TOFF_MIN = TOFF_MIN_DEF,
    parameter logic [15:0] TOFF_MAX = TOFF_MAX_DEF,
    parameter logic [15:0] IP_MAX   = IP_MAX_DEF,
    parameter logic [15:0] TON_RST  = TON_RST_DEF,
    parameter logic [15:0] TOFF_RST = TOFF_RST_DEF,
    parameter logic [15:0] IP_RST   = IP_RST_DEF,
    parameter logic [15:0] WAVE_RST = WAVE_RST_DEF,
    parameter logic [15:0] STOP_TMO = STOP_TMO_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_spi,
    input  logic        stop_spi,
    input  logic        start_key,
    input  logic        stop_key,
    input  logic        ton_wr,
    input  logic [15:0] ton_din,
    input  logic        toff_wr,
    input  logic [15:0] toff_din,
    input  logic        ip_wr,
    input  logic [15:0] ip_din,
    input  logic        wave_wr,
    input  logic [15:0] wave_din,
    input  logic        pulse_boundary,
    output logic [15:0] ton_act,
    output logic [15:0] toff_act,
    output logic [15:0] ip_act,
    output logic [15:0] wave_act,
    output logic        param_update,
    output logic        run_en,
    output logic        pending,
    output logic [3:0]  err_flags,
    output logic        stop_forced,
    output logic [1:0]  state_dbg
);

    // All request and write inputs are single-cycle strobes qualified on the rising
    // clock edge; there is no back-pressure, every strobe is consumed the cycle it arrives.

    sched_state_t state, state_nxt;

    logic [15:0] ton_sh, toff_sh, ip_sh, wave_sh;
    logic        err_ton, err_toff, err_ip, err_wave;
    logic        start_req, stop_req;
    logic        drain_timeout;
    logic        commit;
    logic        wave_ok;
    logic [15:0] drain_cnt;

    param_shadow_reg #(.MIN(TON_MIN), .MAX(TON_MAX), .RST(TON_RST)) u_ton (
        .clk    (clk),
        .rst    (rst),
        .wr     (ton_wr),
        .din    (ton_din),
        .shadow (ton_sh),
        .err    (err_ton)
    );

    param_shadow_reg #(.MIN(TOFF_MIN), .MAX(TOFF_MAX), .RST(TOFF_RST)) u_toff (
        .clk    (clk),
        .rst    (rst),
        .wr     (toff_wr),
        .din    (toff_din),
        .shadow (toff_sh),
        .err    (err_toff)
    );

    param_shadow_reg #(.MIN(IP_MIN_DEF), .MAX(IP_MAX), .RST(IP_RST)) u_ip (
        .clk    (clk),
        .rst    (rst),
        .wr     (ip_wr),
        .din    (ip_din),
        .shadow (ip_sh),
        .err    (err_ip)
    );

    // Switching BUCK<->RES under an enabled generator is unsafe, so the topology bit
    // is frozen against the active waveform whenever run_en is high.
    assign wave_ok = wave_shape_legal(wave_din) &&
                     !(run_en && (wave_din[WAVE_RES_BIT] != wave_act[WAVE_RES_BIT]));

    always_ff @(posedge clk) begin
        if (rst) begin
            wave_sh  <= WAVE_RST;
            err_wave <= 1'b0;
        end else if (wave_wr) begin
            if (wave_ok) begin
                wave_sh  <= wave_din;
                err_wave <= 1'b0;
            end else begin
                err_wave <= 1'b1;
            end
        end
    end

    assign err_flags[ERR_TON]  = err_ton;
    assign err_flags[ERR_TOFF] = err_toff;
    assign err_flags[ERR_IP]   = err_ip;
    assign err_flags[ERR_WAVE] = err_wave;

    assign pending = (ton_sh != ton_act) || (toff_sh != toff_act) ||
                     (ip_sh != ip_act) || (wave_sh != wave_act);

    assign start_req = start_spi | start_key;
    assign stop_req  = stop_spi | stop_key;

    assign drain_timeout = (state == DRAIN) && !pulse_boundary &&
                           (drain_cnt == STOP_TMO - 16'd1);

    // Shadows are sampled from registers, so a write on the boundary cycle misses it.
    assign commit = pending &&
                    ((state == STOPPED) || ((state == RUNNING) && pulse_boundary));

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= STOPPED;
        else
            state <= state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            STOPPED: if (start_req && !stop_req) state_nxt = RUNNING;
            RUNNING: if (stop_req)               state_nxt = DRAIN;
            DRAIN:   if (pulse_boundary || drain_timeout) state_nxt = STOPPED;
            default: state_nxt = STOPPED;
        endcase
    end

    // FSM outputs
    always_comb begin
        run_en    = 1'b0;
        state_dbg = state;
        if (state != STOPPED)
            run_en = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst || (state != DRAIN))
            drain_cnt <= 16'd0;
        else
            drain_cnt <= drain_cnt + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            stop_forced <= 1'b0;
        else
            stop_forced <= drain_timeout;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ton_act      <= TON_RST;
            toff_act     <= TOFF_RST;
            ip_act       <= IP_RST;
            wave_act     <= WAVE_RST;
            param_update <= 1'b0;
        end else begin
            param_update <= commit;
            if (commit) begin
                ton_act  <= ton_sh;
                toff_act <= toff_sh;
                ip_act   <= ip_sh;
                wave_act <= wave_sh;
            end
        end
    end

endmodule

// File: tb/tb_discharge_param_scheduler.sv
// Directed bench for discharge_param_scheduler: reset values, commit timing when
// stopped and at pulse boundaries, range/waveform rejection, arbitration and drain timeout.
module tb_discharge_param_scheduler;
    import edm_pkg::*;

    localparam int STOP_TMO = 20000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_spi = 1'b0, stop_spi = 1'b0, start_key = 1'b0, stop_key = 1'b0;
    logic        ton_wr = 1'b0, toff_wr = 1'b0, ip_wr = 1'b0, wave_wr = 1'b0;
    logic [15:0] ton_din = '0, toff_din = '0, ip_din = '0, wave_din = '0;
    logic        pulse_boundary = 1'b0;
    logic [15:0] ton_act, toff_act, ip_act, wave_act;
    logic        param_update, run_en, pending, stop_forced;
    logic [3:0]  err_flags;
    logic [1:0]  state_dbg;

    int n_total = 0;
    int n_pass  = 0;

    discharge_param_scheduler dut (
        .clk            (clk),
        .rst            (rst),
        .start_spi      (start_spi),
        .stop_spi       (stop_spi),
        .start_key      (start_key),
        .stop_key       (stop_key),
        .ton_wr         (ton_wr),
        .ton_din        (ton_din),
        .toff_wr        (toff_wr),
        .toff_din       (toff_din),
        .ip_wr          (ip_wr),
        .ip_din         (ip_din),
        .wave_wr        (wave_wr),
        .wave_din       (wave_din),
        .pulse_boundary (pulse_boundary),
        .ton_act        (ton_act),
        .toff_act       (toff_act),
        .ip_act         (ip_act),
        .wave_act       (wave_act),
        .param_update   (param_update),
        .run_en         (run_en),
        .pending        (pending),
        .err_flags      (err_flags),
        .stop_forced    (stop_forced),
        .state_dbg      (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr_ton(input logic [15:0] v);
        ton_wr = 1'b1; ton_din = v; tick(); ton_wr = 1'b0;
    endtask

    task automatic wr_toff(input logic [15:0] v);
        toff_wr = 1'b1; toff_din = v; tick(); toff_wr = 1'b0;
    endtask

    task automatic wr_ip(input logic [15:0] v);
        ip_wr = 1'b1; ip_din = v; tick(); ip_wr = 1'b0;
    endtask

    task automatic wr_wave(input logic [15:0] v);
        wave_wr = 1'b1; wave_din = v; tick(); wave_wr = 1'b0;
    endtask

    int  n_run;
    logic saw_forced;

    initial begin
        // reset
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_ton_act",  ton_act,  16'd100);
        check("rst_toff_act", toff_act, 16'd1000);
        check("rst_ip_act",   ip_act,   16'd20);
        check("rst_wave_act", wave_act, 16'h2001);
        check("rst_run_en",   run_en,   1'b0);
        check("rst_pending",  pending,  1'b0);
        check("rst_err",      err_flags, 4'b0000);
        check("rst_update",   param_update, 1'b0);
        check("rst_forced",   stop_forced, 1'b0);
        check("rst_state",    state_dbg, STOPPED);

        // stopped commit: write at N, active at N+2
        wr_ton(16'd200);
        check("t1_pending_n1",  pending, 1'b1);
        check("t1_ton_act_n1",  ton_act, 16'd100);
        check("t1_update_n1",   param_update, 1'b0);
        tick();
        check("t1_ton_act_n2",  ton_act, 16'd200);
        check("t1_update_n2",   param_update, 1'b1);
        check("t1_pending_n2",  pending, 1'b0);
        check("t1_err",         err_flags, 4'b0000);
        tick();
        check("t1_update_n3",   param_update, 1'b0);

        // range boundaries
        wr_ton(16'd5001);
        check("t3_ton_err",     err_flags, 4'b0001);
        tick();
        check("t3_ton_unch",    ton_act, 16'd200);
        check("t3_no_pending",  pending, 1'b0);
        wr_ton(16'd5000);
        check("t3_ton_err_clr", err_flags, 4'b0000);
        tick();
        check("t3_ton_max",     ton_act, 16'd5000);
        wr_ip(16'd0);
        check("t3_ip_zero_err", err_flags, 4'b0100);
        wr_ip(16'd121);
        check("t3_ip_121_err",  err_flags, 4'b0100);
        wr_ip(16'd120);
        check("t3_ip_ok",       err_flags, 4'b0000);
        tick();
        check("t3_ip_act",      ip_act, 16'd120);
        wr_toff(16'd19);
        check("t3_toff_err",    err_flags, 4'b0010);
        tick();
        check("t3_toff_unch",   toff_act, 16'd1000);

        // arbitration
        start_key = 1'b1; stop_spi = 1'b1;
        tick();
        start_key = 1'b0; stop_spi = 1'b0;
        check("t4_stop_wins",   run_en, 1'b0);
        start_spi = 1'b1;
        tick();
        start_spi = 1'b0;
        check("t4_start",       run_en, 1'b1);
        check("t4_state_run",   state_dbg, RUNNING);
        start_key = 1'b1;
        tick();
        start_key = 1'b0;
        check("t4_start_ign",   state_dbg, RUNNING);

        // running: commit only on pulse boundary
        wr_toff(16'd500);
        wr_ip(16'd50);
        check("t2_pending",     pending, 1'b1);
        check("t2_toff_hold",   toff_act, 16'd1000);
        repeat (8) tick();
        check("t2_toff_hold2",  toff_act, 16'd1000);
        check("t2_ip_hold",     ip_act, 16'd120);
        pulse_boundary = 1'b1; ton_wr = 1'b1; ton_din = 16'd300;
        tick();
        pulse_boundary = 1'b0; ton_wr = 1'b0;
        check("t2_toff_commit", toff_act, 16'd500);
        check("t2_ip_commit",   ip_act, 16'd50);
        check("t2_update",      param_update, 1'b1);
        check("t2_ton_excl",    ton_act, 16'd5000);
        check("t2_still_pend",  pending, 1'b1);
        tick();
        check("t2_update_off",  param_update, 1'b0);
        check("t2_ton_wait",    ton_act, 16'd5000);
        pulse_boundary = 1'b1;
        tick();
        pulse_boundary = 1'b0;
        check("t2_ton_commit",  ton_act, 16'd300);
        check("t2_no_pending",  pending, 1'b0);

        // topology change rejected while running
        wr_wave(16'h8000);
        check("t6_wave_err",    err_flags, 4'b1000);
        tick();
        check("t6_wave_unch",   wave_act, 16'h2001);
        check("t6_wave_nopend", pending, 1'b0);
        wr_wave(16'h0004);
        check("t6_shape_err",   err_flags, 4'b1000);

        // drain ended by a boundary, then the topology write is accepted
        stop_spi = 1'b1;
        tick();
        stop_spi = 1'b0;
        check("dr_state",       state_dbg, DRAIN);
        check("dr_run_en",      run_en, 1'b1);
        start_key = 1'b1;
        tick();
        start_key = 1'b0;
        check("dr_start_ign",   state_dbg, DRAIN);
        pulse_boundary = 1'b1;
        tick();
        pulse_boundary = 1'b0;
        check("dr_stopped",     run_en, 1'b0);
        check("dr_no_forced",   stop_forced, 1'b0);
        stop_key = 1'b1;
        tick();
        stop_key = 1'b0;
        check("dr_stop_ign",    state_dbg, STOPPED);
        wr_wave(16'h8000);
        check("t6_wave_ok",     err_flags, 4'b0000);
        tick();
        check("t6_wave_act",    wave_act, 16'h8000);
        check("t6_wave_update", param_update, 1'b1);

        // drain timeout
        start_spi = 1'b1;
        tick();
        start_spi = 1'b0;
        check("t5_running",     run_en, 1'b1);
        stop_key = 1'b1;
        tick();
        stop_key = 1'b0;
        n_run = 0;
        saw_forced = 1'b0;
        while (run_en === 1'b1 && n_run < STOP_TMO + 5) begin
            n_run++;
            if (stop_forced === 1'b1) saw_forced = 1'b1;
            tick();
        end
        check("t5_drain_len",   n_run, STOP_TMO);
        check("t5_early_force", saw_forced, 1'b0);
        check("t5_forced",      stop_forced, 1'b1);
        check("t5_state",       state_dbg, STOPPED);
        tick();
        check("t5_forced_off",  stop_forced, 1'b0);

        // reset while running drops run_en and pending writes
        start_spi = 1'b1;
        tick();
        start_spi = 1'b0;
        wr_ton(16'd400);
        check("rr_pending",     pending, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rr_run_en",      run_en, 1'b0);
        check("rr_ton_act",     ton_act, 16'd100);
        check("rr_wave_act",    wave_act, 16'h2001);
        check("rr_pending_clr", pending, 1'b0);
        tick();
        check("rr_ton_stays",   ton_act, 16'd100);
        check("rr_no_update",   param_update, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
